alk_litcarry: RTL
=================

Name: alk_litcarry

Overview:
- Sequential stage directly downstream of the ALK MUX decode.
- Consumes force_cout0_l and produces the long_lit_l qualifier that the decode consumes.
- Sequences 32-bit long-literal fetches from the instruction buffer as two 16-bit IB words.
- Latches the ALU carry-out per microcycle, honouring forced-zero, and keeps a saved carry for multi-precision microsequences.

Parameters:
- IBW, 16, width of one instruction-buffer word.
- MAXWAIT, 7, maximum cycles waiting on IB before a literal fetch aborts with lit_err_h.

Ports:
- clk_h  in  1  microcycle clock; all state changes on rising edge
- reset_h  in  1  asynchronous, active-high reset
- stall_h  in  1  global microcycle stall; freezes all state
- long_lit_req_h  in  1  microword requests a 32-bit literal; sampled in IDLE only
- ib_valid_h  in  1  IB word available this cycle
- ib_data_h  in  IBW  IB word
- cout_raw_h  in  1  ALU carry-out, current cycle
- force_cout0_l  in  1  from MUX decode; low forces latched carry to 0
- latch_c_h  in  1  microword enable for carry latch
- save_c_h  in  1  copy latched carry into saved carry
- use_sav_h  in  1  present saved carry as carry-in
- long_lit_l  out  1  low while a long literal is in flight or held
- ib_take_h  out  1  IB word consumed this cycle (combinational)
- lit_stall_h  out  1  request microsequencer stall while waiting on IB
- lit_data_h  out  2*IBW  assembled literal: low word first, then high word
- lit_err_h  out  1  one-cycle pulse on wait-timeout abort
- cout_h  out  1  latched carry
- cin_h  out  1  carry-in to ALU

Behaviour:
- Reset (async, any state) forces:
  - state IDLE, long_lit_l=1, lit_stall_h=0, lit_err_h=0
  - lit_data_h=0, cout_h=0, saved carry=0, wait counter=0
- States:
  - IDLE: long_lit_req_h=1 -> LO; long_lit_l goes low the next cycle.
  - LO: ib_valid_h=1 -> ib_take_h=1, load lit_data_h[IBW-1:0] -> HI.
  - HI: ib_valid_h=1 -> ib_take_h=1, load lit_data_h[2*IBW-1:IBW] -> HOLD.
  - HOLD: exactly one cycle; literal valid, long_lit_l=0 -> IDLE. long_lit_l returns high the cycle after HOLD.
  - A request seen in HOLD is ignored; requests are accepted only in IDLE.
- ib_take_h = (state LO or HI) & ib_valid_h & ~stall_h. It is the only path by which the IB advances.
- lit_stall_h = (state LO or HI) & ~ib_valid_h.
- Wait counter (3 bits):
  - Increments each non-stalled cycle in LO/HI with ib_valid_h=0.
  - Clears on any take and in IDLE.
  - Reaching MAXWAIT -> next cycle lit_err_h pulses, state -> IDLE, long_lit_l=1, lit_data_h retains its partial contents.
- Carry latch, non-stalled cycle with latch_c_h=1:
  - cout_h <= cout_raw_h & force_cout0_l & long_lit_l.
  - The current long_lit_l is used, so no carry propagates out of a literal-pass cycle.
  - latch_c_h=0 holds cout_h.
- save_c_h=1 -> saved carry <= cout_h, the pre-update value. When save_c_h and latch_c_h coincide, the save captures the old value.
- cin_h = use_sav_h ? saved carry : cout_h (combinational).
- stall_h=1 freezes state, counter, lit_data_h, cout_h and saved carry. ib_take_h is 0 and lit_err_h is not generated while stalled.
- No arithmetic wrap: the counter saturates at MAXWAIT because abort occurs there.

Test Plan:
- Reset mid-HI with lit_data_h low word 0x1234 -> all outputs return to reset values immediately (async), state IDLE.
- Request, then ib_data 0xBEEF (valid), then 0xDEAD (valid) -> ib_take_h pulses two cycles; HOLD shows lit_data_h=0xDEADBEEF; long_lit_l low for exactly 3 cycles.
- Request, ib_valid_h low for 7 cycles in LO -> lit_stall_h high throughout; lit_err_h single pulse; long_lit_l high after; no ib_take_h.
- latch_c_h=1, cout_raw_h=1:
  - force_cout0_l=0 -> cout_h=0
  - force_cout0_l=1 in IDLE -> cout_h=1
  - force_cout0_l=1 during LO -> cout_h=0
- cout_h=1, then save_c_h=1 with latch_c_h=1 and cout_raw_h=0 -> saved=1, cout_h=0; use_sav_h=1 -> cin_h=1.
- stall_h=1 for 3 cycles in HI with ib_valid_h=1 -> no take, counter unchanged, state HI held; release -> take occurs next cycle.

Source files
------------

// File: rtl/alk_litcarry_if.sv
// Handshake bundle between the microsequencer/IB side and the literal/carry stage.
interface alk_litcarry_if #(
  parameter int IBW = 16
);
  logic             stall_h;
  logic             long_lit_req_h;
  logic             ib_valid_h;
  logic [IBW-1:0]   ib_data_h;
  logic             cout_raw_h;
  logic             force_cout0_l;
  logic             latch_c_h;
  logic             save_c_h;
  logic             use_sav_h;
  logic             long_lit_l;
  logic             ib_take_h;
  logic             lit_stall_h;
  logic [2*IBW-1:0] lit_data_h;
  logic             lit_err_h;
  logic             cout_h;
  logic             cin_h;

  // Driver side: microsequencer, IB and ALU.
  modport master (
    output stall_h, long_lit_req_h, ib_valid_h, ib_data_h, cout_raw_h,
           force_cout0_l, latch_c_h, save_c_h, use_sav_h,
    input  long_lit_l, ib_take_h, lit_stall_h, lit_data_h, lit_err_h,
           cout_h, cin_h
  );

  // The literal/carry stage itself.
  modport slave (
    input  stall_h, long_lit_req_h, ib_valid_h, ib_data_h, cout_raw_h,
           force_cout0_l, latch_c_h, save_c_h, use_sav_h,
    output long_lit_l, ib_take_h, lit_stall_h, lit_data_h, lit_err_h,
           cout_h, cin_h
  );
endinterface

// File: rtl/alk_litcarry.sv
// ALK long-literal sequencer and carry latch. Fetches a 32-bit literal as two
// IB words (low first), aborts after MAXWAIT empty cycles, and keeps the
// latched / saved ALU carry for multi-precision microsequences.
module alk_litcarry #(
  parameter int IBW     = 16,
  parameter int MAXWAIT = 7
) (
  input  logic          clk_h,
  input  logic          reset_h,
  alk_litcarry_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int            CW        = $clog2(MAXWAIT + 1);
  // Last count before abort: the increment that would reach MAXWAIT aborts instead.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAXWAIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          sav_c;
  logic          fetching;

  assign fetching        = (state == S_LO) || (state == S_HI);
  assign bus.ib_take_h   = fetching & bus.ib_valid_h & ~bus.stall_h;
  assign bus.lit_stall_h = fetching & ~bus.ib_valid_h;
  // Literal is in flight or held in every state except IDLE.
  assign bus.long_lit_l  = (state == S_IDLE);
  assign bus.cin_h       = bus.use_sav_h ? sav_c : bus.cout_h;

  // Literal fetch sequencer, wait counter and abort pulse.
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      bus.lit_data_h <= '0;
      bus.lit_err_h  <= 1'b0;
    end else begin
      // Abort indication is a single-cycle pulse regardless of stall.
      bus.lit_err_h <= 1'b0;
      if (!bus.stall_h) begin
        case (state)
          S_IDLE: begin
            wait_cnt <= '0;
            if (bus.long_lit_req_h) state <= S_LO;
          end
          S_LO, S_HI: begin
            if (bus.ib_valid_h) begin
              wait_cnt <= '0;
              if (state == S_LO) begin
                bus.lit_data_h[IBW-1:0] <= bus.ib_data_h;
                state                   <= S_HI;
              end else begin
                bus.lit_data_h[2*IBW-1:IBW] <= bus.ib_data_h;
                state                       <= S_HOLD;
              end
            end else if (wait_cnt == WAIT_LAST) begin
              // Partial literal stays in lit_data_h for debug visibility.
              wait_cnt      <= '0;
              bus.lit_err_h <= 1'b1;
              state         <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
          default: begin
            wait_cnt <= '0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Carry latch and saved carry; save samples the pre-update latched value.
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      bus.cout_h <= 1'b0;
      sav_c      <= 1'b0;
    end else if (!bus.stall_h) begin
      if (bus.save_c_h)  sav_c      <= bus.cout_h;
      // Current long_lit_l gates the carry so literal-pass cycles never leak one.
      if (bus.latch_c_h) bus.cout_h <= bus.cout_raw_h & bus.force_cout0_l & bus.long_lit_l;
    end
  end

endmodule
